// File: rtl/pz_regfile_pkg.sv
// Shared constants, state encodings and helpers for the pole/zero AXI-Lite register file.
package pz_regfile_pkg;

  // Word indices within the register map
  localparam int CTRL      = 0;
  localparam int COUNTS    = 1;
  localparam int STATUS    = 2;
  localparam int FRAME_CNT = 3;
  localparam int SLOT_BASE = 4;

  // CTRL bit positions
  localparam int CTRL_COMMIT_BIT = 0;
  localparam int CTRL_AUTO_BIT   = 1;

  // AXI response codes
  localparam logic [1:0] AXI_OK     = 2'b00;
  localparam logic [1:0] AXI_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    W_IDLE = 3'd0,
    W_DATA = 3'd1,
    W_ADDR = 3'd2,
    W_EXEC = 3'd3,
    W_RESP = 3'd4
  } wr_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_t;

  // Merge a new word into an old one, byte lane by byte lane.
  function automatic logic [31:0] apply_strb(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  strb);
    apply_strb = old_w;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) apply_strb[8*b +: 8] = new_w[8*b +: 8];
    end
  endfunction

endpackage

// File: rtl/axil_reg_slave.sv
// AXI-Lite slave front end: independent write and read handshake FSMs that
// turn bus beats into a one-cycle register write strobe and a read lookup.
module axil_reg_slave
  import pz_regfile_pkg::*;
#(
  parameter  int AXI_LITE_ADDR_WIDTH = 8,
  localparam int IDX_W               = AXI_LITE_ADDR_WIDTH - 2
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  input  logic [AXI_LITE_ADDR_WIDTH-1:0] s_axi_lite_awaddr,
  input  logic                           s_axi_lite_awvalid,
  output logic                           s_axi_lite_awready,
  input  logic [31:0]                    s_axi_lite_wdata,
  input  logic [3:0]                     s_axi_lite_wstrb,
  input  logic                           s_axi_lite_wvalid,
  output logic                           s_axi_lite_wready,
  output logic [1:0]                     s_axi_lite_bresp,
  output logic                           s_axi_lite_bvalid,
  input  logic                           s_axi_lite_bready,
  input  logic [AXI_LITE_ADDR_WIDTH-1:0] s_axi_lite_araddr,
  input  logic                           s_axi_lite_arvalid,
  output logic                           s_axi_lite_arready,
  output logic [31:0]                    s_axi_lite_rdata,
  output logic [1:0]                     s_axi_lite_rresp,
  output logic                           s_axi_lite_rvalid,
  input  logic                           s_axi_lite_rready,
  output logic                           wr_en,
  output logic [IDX_W-1:0]               wr_idx,
  output logic [31:0]                    wr_data,
  output logic [3:0]                     wr_strb,
  input  logic                           wr_err,
  output logic [IDX_W-1:0]               rd_idx,
  input  logic [31:0]                    rd_data,
  input  logic                           rd_err
);

  wr_state_t w_state, w_next;
  rd_state_t r_state, r_next;
  logic      rst_done;
  logic      aw_hs, w_hs, ar_hs;
  logic      unused_addr_lsbs;

  assign unused_addr_lsbs = ^{s_axi_lite_awaddr[1:0], s_axi_lite_araddr[1:0]};

  // Keep every ready low until the first edge after reset release.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) rst_done <= 1'b0;
    else          rst_done <= 1'b1;
  end

  assign s_axi_lite_awready = rst_done && (w_state == W_IDLE || w_state == W_ADDR);
  assign s_axi_lite_wready  = rst_done && (w_state == W_IDLE || w_state == W_DATA);
  assign s_axi_lite_bvalid  = (w_state == W_RESP);
  assign s_axi_lite_arready = rst_done && (r_state == R_IDLE);
  assign s_axi_lite_rvalid  = (r_state == R_DATA);

  assign aw_hs = s_axi_lite_awvalid && s_axi_lite_awready;
  assign w_hs  = s_axi_lite_wvalid  && s_axi_lite_wready;
  assign ar_hs = s_axi_lite_arvalid && s_axi_lite_arready;

  assign wr_en  = (w_state == W_EXEC);
  assign rd_idx = s_axi_lite_araddr[2 +: IDX_W];

  // Write FSM state register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) w_state <= W_IDLE;
    else          w_state <= w_next;
  end

  // Write FSM next state: collect AW and W in either order, execute, respond.
  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE: begin
        if (aw_hs && w_hs) w_next = W_EXEC;
        else if (aw_hs)    w_next = W_DATA;
        else if (w_hs)     w_next = W_ADDR;
      end
      W_DATA:  if (w_hs)  w_next = W_EXEC;
      W_ADDR:  if (aw_hs) w_next = W_EXEC;
      W_EXEC:  w_next = W_RESP;
      W_RESP:  if (s_axi_lite_bready) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  // Latch the address and data beats; record the response as the write executes.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_idx           <= '0;
      wr_data          <= '0;
      wr_strb          <= '0;
      s_axi_lite_bresp <= AXI_OK;
    end else begin
      if (aw_hs) wr_idx <= s_axi_lite_awaddr[2 +: IDX_W];
      if (w_hs) begin
        wr_data <= s_axi_lite_wdata;
        wr_strb <= s_axi_lite_wstrb;
      end
      if (w_state == W_EXEC) s_axi_lite_bresp <= wr_err ? AXI_SLVERR : AXI_OK;
    end
  end

  // Read FSM state register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_state <= R_IDLE;
    else          r_state <= r_next;
  end

  // Read FSM next state: accept an address, hold the beat until rready.
  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_next = R_DATA;
      R_DATA:  if (s_axi_lite_rready) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  // Register read data and response at the address handshake.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      s_axi_lite_rdata <= '0;
      s_axi_lite_rresp <= AXI_OK;
    end else if (ar_hs) begin
      s_axi_lite_rdata <= rd_err ? 32'd0 : rd_data;
      s_axi_lite_rresp <= rd_err ? AXI_SLVERR : AXI_OK;
    end
  end

endmodule

// File: rtl/pz_axil_regfile.sv
// Pole/zero control register file: staging slots and counts written over
// AXI-Lite, copied to the active set only at a frame boundary.
module pz_axil_regfile
  import pz_regfile_pkg::*;
#(
  parameter  int AXI_LITE_ADDR_WIDTH = 8,
  parameter  int NUM_SLOTS           = 8,
  localparam int CNT_W               = $clog2(NUM_SLOTS + 1)
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  input  logic [AXI_LITE_ADDR_WIDTH-1:0] s_axi_lite_awaddr,
  input  logic                           s_axi_lite_awvalid,
  output logic                           s_axi_lite_awready,
  input  logic [31:0]                    s_axi_lite_wdata,
  input  logic [3:0]                     s_axi_lite_wstrb,
  input  logic                           s_axi_lite_wvalid,
  output logic                           s_axi_lite_wready,
  output logic [1:0]                     s_axi_lite_bresp,
  output logic                           s_axi_lite_bvalid,
  input  logic                           s_axi_lite_bready,
  input  logic [AXI_LITE_ADDR_WIDTH-1:0] s_axi_lite_araddr,
  input  logic                           s_axi_lite_arvalid,
  output logic                           s_axi_lite_arready,
  output logic [31:0]                    s_axi_lite_rdata,
  output logic [1:0]                     s_axi_lite_rresp,
  output logic                           s_axi_lite_rvalid,
  input  logic                           s_axi_lite_rready,
  input  logic                           frame_start,
  output logic [32*NUM_SLOTS-1:0]        slots_flat,
  output logic [CNT_W-1:0]               no_z,
  output logic [CNT_W-1:0]               no_p,
  output logic                           commit_pulse
);

  localparam int IDX_W = AXI_LITE_ADDR_WIDTH - 2;

  if ((4 + NUM_SLOTS) * 4 > 2 ** AXI_LITE_ADDR_WIDTH) begin : g_addr_chk
    $error("pz_axil_regfile: register map does not fit in AXI_LITE_ADDR_WIDTH");
  end
  if (NUM_SLOTS < 1 || NUM_SLOTS > 255) begin : g_slot_chk
    $error("pz_axil_regfile: NUM_SLOTS must be 1..255");
  end

  logic              wr_en, wr_err, rd_err;
  logic [IDX_W-1:0]  wr_idx, rd_idx;
  logic [31:0]       wr_data, rd_data;
  logic [3:0]        wr_strb;

  logic [31:0]       staging [NUM_SLOTS];
  logic [31:0]       active  [NUM_SLOTS];
  logic [CNT_W-1:0]  stg_z, stg_p;
  logic              pending, auto_en, commit;
  logic [15:0]       commit_cnt;
  logic [31:0]       frame_cnt;
  logic [31:0]       ctrl_word, counts_word, status_word, counts_merged;
  logic [15:0]       counts_clamped;
  logic              wr_ctrl, wr_counts;

  // Clamp a raw {no_p, no_z} pair so zeros and poles never exceed the slot count.
  function automatic logic [15:0] clamp_counts(input logic [15:0] raw);
    int z, p;
    z = int'(raw[7:0]);
    p = int'(raw[15:8]);
    if (z > NUM_SLOTS)     z = NUM_SLOTS;
    if (p > NUM_SLOTS - z) p = NUM_SLOTS - z;
    clamp_counts = {8'(p), 8'(z)};
  endfunction

  axil_reg_slave #(
    .AXI_LITE_ADDR_WIDTH (AXI_LITE_ADDR_WIDTH)
  ) u_slave (
    .aclk               (aclk),
    .aresetn            (aresetn),
    .s_axi_lite_awaddr  (s_axi_lite_awaddr),
    .s_axi_lite_awvalid (s_axi_lite_awvalid),
    .s_axi_lite_awready (s_axi_lite_awready),
    .s_axi_lite_wdata   (s_axi_lite_wdata),
    .s_axi_lite_wstrb   (s_axi_lite_wstrb),
    .s_axi_lite_wvalid  (s_axi_lite_wvalid),
    .s_axi_lite_wready  (s_axi_lite_wready),
    .s_axi_lite_bresp   (s_axi_lite_bresp),
    .s_axi_lite_bvalid  (s_axi_lite_bvalid),
    .s_axi_lite_bready  (s_axi_lite_bready),
    .s_axi_lite_araddr  (s_axi_lite_araddr),
    .s_axi_lite_arvalid (s_axi_lite_arvalid),
    .s_axi_lite_arready (s_axi_lite_arready),
    .s_axi_lite_rdata   (s_axi_lite_rdata),
    .s_axi_lite_rresp   (s_axi_lite_rresp),
    .s_axi_lite_rvalid  (s_axi_lite_rvalid),
    .s_axi_lite_rready  (s_axi_lite_rready),
    .wr_en              (wr_en),
    .wr_idx             (wr_idx),
    .wr_data            (wr_data),
    .wr_strb            (wr_strb),
    .wr_err             (wr_err),
    .rd_idx             (rd_idx),
    .rd_data            (rd_data),
    .rd_err             (rd_err)
  );

  // A commit request written in the frame_start cycle is not yet visible here,
  // so it waits for the following frame.
  assign commit = frame_start && (pending || auto_en);

  assign ctrl_word      = {30'd0, auto_en, pending};
  assign counts_word    = {16'd0, 8'(stg_p), 8'(stg_z)};
  assign status_word    = {commit_cnt, 15'd0, pending};
  assign counts_merged  = apply_strb(counts_word, wr_data, wr_strb);
  assign counts_clamped = clamp_counts(counts_merged[15:0]);
  assign wr_ctrl        = wr_en && (int'(wr_idx) == CTRL);
  assign wr_counts      = wr_en && (int'(wr_idx) == COUNTS);

  // Write decode: only CTRL, COUNTS and the staging slots accept writes.
  always_comb begin
    wr_err = 1'b1;
    if (int'(wr_idx) == CTRL || int'(wr_idx) == COUNTS) wr_err = 1'b0;
    else if (int'(wr_idx) >= SLOT_BASE && int'(wr_idx) < SLOT_BASE + NUM_SLOTS) wr_err = 1'b0;
  end

  // Read mux; slot words return the staging copy, not the active one.
  always_comb begin
    rd_data = '0;
    rd_err  = 1'b0;
    if (int'(rd_idx) == CTRL)           rd_data = ctrl_word;
    else if (int'(rd_idx) == COUNTS)    rd_data = counts_word;
    else if (int'(rd_idx) == STATUS)    rd_data = status_word;
    else if (int'(rd_idx) == FRAME_CNT) rd_data = frame_cnt;
    else if (int'(rd_idx) >= SLOT_BASE && int'(rd_idx) < SLOT_BASE + NUM_SLOTS) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (int'(rd_idx) == SLOT_BASE + i) rd_data = staging[i];
      end
    end else begin
      rd_err = 1'b1;
    end
  end

  // Staging slots and counts, written by software with byte strobes.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < NUM_SLOTS; i++) staging[i] <= '0;
      stg_z <= '0;
      stg_p <= '0;
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (wr_en && int'(wr_idx) == SLOT_BASE + i)
          staging[i] <= apply_strb(staging[i], wr_data, wr_strb);
      end
      if (wr_counts) begin
        stg_z <= CNT_W'(counts_clamped[7:0]);
        stg_p <= CNT_W'(counts_clamped[15:8]);
      end
    end
  end

  // CTRL flags and the commit/frame counters.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      pending    <= 1'b0;
      auto_en    <= 1'b0;
      commit_cnt <= '0;
      frame_cnt  <= '0;
    end else begin
      if (wr_ctrl && wr_strb[0] && wr_data[CTRL_COMMIT_BIT]) pending <= 1'b1;
      else if (commit)                                       pending <= 1'b0;
      if (wr_ctrl && wr_strb[0]) auto_en <= wr_data[CTRL_AUTO_BIT];
      if (commit)      commit_cnt <= commit_cnt + 16'd1;
      if (frame_start) frame_cnt  <= frame_cnt + 32'd1;
    end
  end

  // Active set: copied from staging in one shot at a committing frame_start.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < NUM_SLOTS; i++) active[i] <= '0;
      no_z         <= '0;
      no_p         <= '0;
      commit_pulse <= 1'b0;
    end else begin
      commit_pulse <= commit;
      if (commit) begin
        for (int i = 0; i < NUM_SLOTS; i++) active[i] <= staging[i];
        no_z <= stg_z;
        no_p <= stg_p;
      end
    end
  end

  // Flatten the active slots onto the output bus.
  always_comb begin
    slots_flat = '0;
    for (int i = 0; i < NUM_SLOTS; i++) slots_flat[32*i +: 32] = active[i];
  end

endmodule
